// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny_dnn control-register AXI4-Lite initiator:
// FSM encoding, AXI response codes and register word indices.
package tiny_dnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_FS   = 4'd1;
  localparam logic [3:0] REG_KS   = 4'd2;
  localparam logic [3:0] REG_KH   = 4'd3;
  localparam logic [3:0] REG_KW   = 4'd4;
  localparam logic [3:0] REG_SS   = 4'd5;
  localparam logic [3:0] REG_ID   = 4'd6;
  localparam logic [3:0] REG_IS   = 4'd7;
  localparam logic [3:0] REG_IH   = 4'd8;
  localparam logic [3:0] REG_IW   = 4'd9;
  localparam logic [3:0] REG_DS   = 4'd10;
  localparam logic [3:0] REG_OD   = 4'd11;
  localparam logic [3:0] REG_OS   = 4'd12;
  localparam logic [3:0] REG_OH   = 4'd13;
  localparam logic [3:0] REG_OW   = 4'd14;
  localparam logic [3:0] REG_DD   = 4'd15;

endpackage

// File: rtl/tiny_dnn_axil_master.sv
// AXI4-Lite initiator: converts a command stream into single register
// transactions, one in flight, and returns each result on a response stream.
module tiny_dnn_axil_master
  import tiny_dnn_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          IDX_W     = 4
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESETN,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [31:0]      cmd_wdata,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_resp,

  output logic [31:0]      M_AXI_AWADDR,
  output logic             M_AXI_AWVALID,
  input  logic             M_AXI_AWREADY,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY,
  output logic [31:0]      M_AXI_ARADDR,
  output logic             M_AXI_ARVALID,
  input  logic             M_AXI_ARREADY,
  input  logic [31:0]      M_AXI_RDATA,
  input  logic [1:0]       M_AXI_RRESP,
  input  logic             M_AXI_RVALID,
  output logic             M_AXI_RREADY
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = {ADDR_BASE[31:IDX_W+2], cmd_idx, 2'b00};
          wdata_d     = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end

      // Address and data channels retire independently, in any order.
      ST_WADDR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end

      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = ST_RSP;
        end
      end

      ST_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end

      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = ST_RSP;
        end
      end

      // Raising cmd_ready on exit gives exactly one IDLE cycle between transactions.
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its
      // neighbours, independent of statement order.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_tiny_dnn_axil_master.sv
// Directed bench for tiny_dnn_axil_master against a behavioural AXI-Lite
// slave whose per-channel READY and response delays are set by each test.
module tb_tiny_dnn_axil_master;
  import tiny_dnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  cmd_idx = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tiny_dnn_axil_master #(.ADDR_BASE(32'h0000_0000), .IDX_W(4)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- behavioural slave ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_done, w_done, b_arm, r_arm, bvalid_r, rvalid_r;
  logic [31:0] got_addr, got_data;
  logic [3:0]  got_strb;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid  && (w_cnt  >= w_delay);
  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign bvalid  = bvalid_r;
  assign rvalid  = rvalid_r;
  assign bresp   = bvalid_r ? bresp_val : 2'b00;
  assign rresp   = rvalid_r ? rresp_val : 2'b00;
  assign rdata   = rvalid_r ? rdata_val : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_arm <= 1'b0; r_arm <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      got_addr <= '0; got_data <= '0; got_strb <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) got_addr <= awaddr;
      if (wvalid && wready) begin
        got_data <= wdata;
        got_strb <= wstrb;
      end
      if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (b_delay == 0) bvalid_r <= 1'b1;
        else begin b_arm <= 1'b1; b_cnt <= b_delay - 1; end
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
      if (b_arm) begin
        if (b_cnt == 0) begin bvalid_r <= 1'b1; b_arm <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (bvalid_r && bready) bvalid_r <= 1'b0;
      if (arvalid && arready) begin
        if (r_delay == 0) rvalid_r <= 1'b1;
        else begin r_arm <= 1'b1; r_cnt <= r_delay - 1; end
      end
      if (r_arm) begin
        if (r_cnt == 0) begin rvalid_r <= 1'b1; r_arm <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
    end
  end

  // Free-running activity counters; tests compare before/after deltas.
  int cyc = 0, ar_hi = 0, rr_hi = 0, br_hi = 0, b_hs = 0, aw_hs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arvalid)            ar_hi <= ar_hi + 1;
    if (rready)             rr_hi <= rr_hi + 1;
    if (bready)             br_hi <= br_hi + 1;
    if (bvalid && bready)   b_hs  <= b_hs + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
  end

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic wr, input logic [3:0] idx, input logic [31:0] data,
                          output int acc);
    cmd_valid = 1'b1; cmd_write = wr; cmd_idx = idx; cmd_wdata = data;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++;
    if (acc < 0) begin bad++; $display("FAIL cmd_accept: no cmd_ready within 50 cycles"); end
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rc = cyc; break; end
    end
    total++;
    if (rc < 0) begin bad++; $display("FAIL rsp_wait: no rsp_valid within 50 cycles"); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                      {awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid});
    end
    total++;
    if ({rsp_write, rsp_rdata, rsp_resp, awaddr, wdata} !== 99'b0) begin
      bad++; $display("FAIL reset_data: rsp_rdata=%h awaddr=%h wdata=%h want 0",
                      rsp_rdata, awaddr, wdata);
    end
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL cmd_ready_pre_edge: got %b want 0", cmd_ready); end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_post_edge: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_zero_wait();
    int acc, rc;
    send_cmd(1'b1, REG_FS, 32'h0000_0123, acc);
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready, rready} !== 4'b1100) begin
      bad++; $display("FAIL wr_valids: got %b want 1100", {awvalid, wvalid, bready, rready});
    end
    total++;
    if (awaddr !== 32'h4 || wdata !== 32'h123 || wstrb !== 4'hF) begin
      bad++; $display("FAIL wr_fields: addr=%h data=%h strb=%h want 4/123/f", awaddr, wdata, wstrb);
    end
    wait_rsp(rc);
    total++;
    if (rc - acc !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", rc - acc); end
    total++;
    if (rsp_write !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL wr_rsp: write=%b resp=%b rdata=%h want 1/00/0", rsp_write, rsp_resp, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_w_first();
    int acc, rc, b0, br0;
    aw_delay = 2; w_delay = 0;
    b0 = b_hs; br0 = br_hi;
    send_cmd(1'b1, REG_SS, 32'h0000_0ABC, acc);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({awvalid, wvalid} !== 2'b10) begin
      bad++; $display("FAIL w_first_split: aw/w got %b want 10", {awvalid, wvalid});
    end
    wait_rsp(rc);
    total++;
    if (b_hs - b0 !== 1 || br_hi - br0 !== 1) begin
      bad++; $display("FAIL w_first_bwait: b_hs=%0d bready_cycles=%0d want 1/1", b_hs - b0, br_hi - br0);
    end
    total++;
    if (got_addr !== 32'h14 || got_data !== 32'hABC || got_strb !== 4'hF) begin
      bad++; $display("FAIL w_first_slave: addr=%h data=%h strb=%h want 14/abc/f", got_addr, got_data, got_strb);
    end
    @(posedge clk); #1;
    aw_delay = 0;
  endtask

  task automatic test_read_delayed();
    int acc, rc, a0, r0;
    r_delay = 4; rdata_val = 32'h0000_0007;
    a0 = ar_hi; r0 = rr_hi;
    send_cmd(1'b0, REG_DD, 32'hFFFF_FFFF, acc);
    @(negedge clk);
    total++;
    if (arvalid !== 1'b1 || araddr !== 32'h3C) begin
      bad++; $display("FAIL rd_ar: arvalid=%b araddr=%h want 1/3c", arvalid, araddr);
    end
    wait_rsp(rc);
    total++;
    if (ar_hi - a0 !== 1 || rr_hi - r0 !== 5) begin
      bad++; $display("FAIL rd_handshake: arvalid_cycles=%0d rready_cycles=%0d want 1/5", ar_hi - a0, rr_hi - r0);
    end
    total++;
    if (rsp_rdata !== 32'h7 || rsp_write !== 1'b0 || rsp_resp !== 2'b00) begin
      bad++; $display("FAIL rd_rsp: rdata=%h write=%b resp=%b want 7/0/00", rsp_rdata, rsp_write, rsp_resp);
    end
    @(posedge clk); #1;
    r_delay = 0;
  endtask

  task automatic test_rsp_stall();
    int acc, rc, acc2, rc2;
    rsp_ready = 1'b0; rdata_val = 32'h0000_0055;
    send_cmd(1'b0, REG_KS, 32'h0, acc);
    wait_rsp(rc);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_idx = REG_KH; cmd_wdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_write, cmd_ready} !== 3'b100 || rsp_rdata !== 32'h55) begin
        bad++; $display("FAIL stall_hold[%0d]: valid/write/cmd_ready=%b rdata=%h want 100/55",
                        i, {rsp_valid, rsp_write, cmd_ready}, rsp_rdata);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL stall_hs: rsp_valid=%b cmd_ready=%b want 1/0", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    acc2 = cyc;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL stall_next_accept: cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (awvalid !== 1'b1 || awaddr !== 32'hC) begin
      bad++; $display("FAIL stall_second_cmd: awvalid=%b awaddr=%h want 1/c", awvalid, awaddr);
    end
    wait_rsp(rc2);
    total++;
    if (rc2 - acc2 !== 3 || got_data !== 32'h77) begin
      bad++; $display("FAIL stall_second_rsp: latency=%0d data=%h want 3/77", rc2 - acc2, got_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slverr();
    int acc, rc, aw0;
    bresp_val = AXI_RESP_SLVERR;
    aw0 = aw_hs;
    send_cmd(1'b1, REG_DS, 32'h5, acc);
    wait_rsp(rc);
    total++;
    if (rsp_resp !== 2'b10 || rsp_write !== 1'b1) begin
      bad++; $display("FAIL slverr_rsp: resp=%b write=%b want 10/1", rsp_resp, rsp_write);
    end
    @(posedge clk); #1;
    bresp_val = AXI_RESP_OKAY; rdata_val = 32'h99;
    send_cmd(1'b0, REG_DS, 32'h0, acc);
    wait_rsp(rc);
    total++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h99 || rc - acc !== 3) begin
      bad++; $display("FAIL slverr_next: resp=%b rdata=%h latency=%0d want 00/99/3", rsp_resp, rsp_rdata, rc - acc);
    end
    @(posedge clk); #1;
    total++;
    if (aw_hs - aw0 !== 1) begin bad++; $display("FAIL slverr_retry: aw handshakes=%0d want 1", aw_hs - aw0); end
  endtask

  task automatic test_reset_mid_write();
    int acc, rc, aw0;
    aw_delay = 5;
    aw0 = aw_hs;
    send_cmd(1'b1, REG_IS, 32'hDEAD, acc);
    @(negedge clk);
    total++;
    if (awvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre: awvalid=%b want 1", awvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      bad++; $display("FAIL midrst_async: got %b want 0000000",
                      {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    aw_delay = 0;
    send_cmd(1'b1, REG_CTRL, 32'h1, acc);
    wait_rsp(rc);
    total++;
    if (got_addr !== 32'h0 || got_data !== 32'h1 || rsp_resp !== 2'b00 || rsp_write !== 1'b1) begin
      bad++; $display("FAIL midrst_clean: addr=%h data=%h resp=%b write=%b want 0/1/00/1",
                      got_addr, got_data, rsp_resp, rsp_write);
    end
    total++;
    if (aw_hs - aw0 !== 1 || rc - acc !== 3) begin
      bad++; $display("FAIL midrst_count: aw handshakes=%0d latency=%0d want 1/3", aw_hs - aw0, rc - acc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_w_first();
    test_read_delayed();
    test_rsp_stall();
    test_slverr();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
